// File: rtl/keynsham_multitimer.sv
// keynsham_multitimer: NUM_TIMERS prescaled down-counters with sticky pending, EOI and per-channel irq
module keynsham_multitimer #(
    parameter int NUM_TIMERS  = 4,
    parameter int COUNT_WIDTH = 32,
    parameter int CH_BITS     = (NUM_TIMERS > 1) ? $clog2(NUM_TIMERS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bus_access,
    input  logic                  timer_cs,
    input  logic [CH_BITS+1:0]    reg_sel,
    input  logic [31:0]           bus_wr_val,
    input  logic                  bus_wr_en,
    input  logic [3:0]            bus_bytesel,
    output logic                  bus_error,
    output logic                  bus_ack,
    output logic [31:0]           bus_data,
    output logic [NUM_TIMERS-1:0] irq
);
    localparam int CW = COUNT_WIDTH;

    logic               access, timer_access, ch_ok;
    logic [CH_BITS-1:0] ch;
    logic [31:0]        wmask, rd;
    logic [31:0]        rd_word [NUM_TIMERS];
    logic               ack_q, err_q;
    logic [31:0]        data_q;

    assign access       = bus_access & timer_cs;
    assign timer_access = access & bus_wr_en;
    assign ch           = reg_sel[CH_BITS+1:2];
    assign ch_ok        = 32'(ch) < 32'(NUM_TIMERS);
    assign wmask        = {{8{bus_bytesel[3]}}, {8{bus_bytesel[2]}}, {8{bus_bytesel[1]}}, {8{bus_bytesel[0]}}};
    assign bus_ack      = ack_q;
    assign bus_error    = err_q;
    assign bus_data     = data_q;

    for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_ch
        logic [CW-1:0] count_q, count_d, reload_q, reload_d, reload_m;
        logic [7:0]    pre_q, pre_d, scale_q, scale_d;
        logic          ien_q, ien_d, en_q, en_d, per_q, per_d, pend_q, pend_d, irq_q;
        logic          sel, wr_reload, wr_ctrl, wr_eoi, wr_b0, disable_wr, enable_rise, tick, expire;

        assign sel         = timer_access & (ch == CH_BITS'(i));
        assign wr_reload   = sel & (reg_sel[1:0] == 2'd1);
        assign wr_ctrl     = sel & (reg_sel[1:0] == 2'd2);
        assign wr_eoi      = sel & (reg_sel[1:0] == 2'd3);
        assign wr_b0       = wr_ctrl & bus_bytesel[0];
        assign disable_wr  = wr_b0 & ~bus_wr_val[1];
        assign enable_rise = wr_b0 & bus_wr_val[1] & ~en_q;
        assign reload_m    = (bus_wr_val[CW-1:0] & wmask[CW-1:0]) | (reload_q & ~wmask[CW-1:0]);
        // a disabling CONTROL write suppresses a tick landing in the same cycle
        assign tick        = en_q & (pre_q == scale_q) & ~disable_wr;
        assign expire      = tick & (count_q == '0);
        assign irq[i]      = irq_q;
        assign rd_word[i]  = reg_sel[1:0] == 2'd0 ? 32'(count_q) :
                             reg_sel[1:0] == 2'd1 ? 32'(reload_q) :
                             reg_sel[1:0] == 2'd2 ? {16'b0, scale_q, 4'b0, pend_q, per_q, en_q, ien_q} : 32'b0;

        // next state: bus writes override the tick, expiry set beats EOI clear
        always_comb begin
            count_d  = wr_reload ? reload_m : !tick ? count_q : expire ? (per_q ? reload_q : '0) : count_q - CW'(1);
            reload_d = wr_reload ? reload_m : reload_q;
            pre_d    = (wr_reload | enable_rise) ? 8'd0 : !en_q ? pre_q : (pre_q == scale_q) ? 8'd0 : pre_q + 8'd1;
            ien_d    = wr_b0 ? bus_wr_val[0] : ien_q;
            en_d     = wr_b0 ? bus_wr_val[1] : (expire & ~per_q) ? 1'b0 : en_q;
            per_d    = wr_b0 ? bus_wr_val[2] : per_q;
            scale_d  = (wr_ctrl & bus_bytesel[1]) ? bus_wr_val[15:8] : scale_q;
            pend_d   = expire | (pend_q & ~wr_eoi);
        end

        // channel state registers; irq follows pending & enable one cycle later
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                count_q  <= '1;
                reload_q <= '1;
                pre_q    <= '0;
                scale_q  <= '0;
                ien_q    <= 1'b0;
                en_q     <= 1'b0;
                per_q    <= 1'b0;
                pend_q   <= 1'b0;
                irq_q    <= 1'b0;
            end else begin
                count_q  <= count_d;
                reload_q <= reload_d;
                pre_q    <= pre_d;
                scale_q  <= scale_d;
                ien_q    <= ien_d;
                en_q     <= en_d;
                per_q    <= per_d;
                pend_q   <= pend_d;
                irq_q    <= pend_q & ien_q;
            end
        end
    end

    // read mux; an out-of-range channel matches nothing and reads 0
    always_comb begin
        rd = '0;
        for (int k = 0; k < NUM_TIMERS; k++)
            if (ch == CH_BITS'(k)) rd = rd_word[k];
    end

    // bus response registered one cycle after the access, from pre-write state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            data_q <= '0;
        end else begin
            ack_q  <= access;
            err_q  <= access & ~ch_ok;
            data_q <= access ? rd : '0;
        end
    end
endmodule
